// File: rtl/uart_receiver.sv
// UART receiver: 2-flop synchronized rx, oversampled bit timing, 2-of-3 majority
// voting around mid-bit, stop-bit check with framing error and line-break hold-off.
module uart_receiver #(
  parameter int unsigned UART_BITS_TRANSFERED = 8,
  parameter int unsigned OVERSAMPLE           = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            baud_tick,
  input  logic                            rx,
  output logic [UART_BITS_TRANSFERED-1:0] message,
  output logic                            valid,
  output logic                            framing_error,
  output logic                            busy
);

  localparam int unsigned W      = UART_BITS_TRANSFERED;
  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned MID    = OVERSAMPLE / 2;

  localparam logic [TICK_W-1:0] IDX_LO   = TICK_W'(MID - 1);
  localparam logic [TICK_W-1:0] IDX_MID  = TICK_W'(MID);
  localparam logic [TICK_W-1:0] IDX_HI   = TICK_W'(MID + 1);
  localparam logic [TICK_W-1:0] IDX_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(W - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  state_t            state, state_n;
  logic              rx_meta, rx_s;
  logic [TICK_W-1:0] tick_cnt, tick_n, tick_inc;
  logic [BIT_W-1:0]  bit_cnt, bit_n;
  logic [1:0]        samp, samp_n;
  logic [W-1:0]      shreg, shreg_n;
  logic [W:0]        shift_tmp;
  logic [W-1:0]      message_n;
  logic              valid_n, fe_n;
  logic              maj;

  // Two-flop synchronizer on the asynchronous serial line
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Majority of the samples taken at M-1, M and the live sample at M+1
  assign maj       = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
  assign tick_inc  = (tick_cnt == IDX_LAST) ? '0 : tick_cnt + TICK_W'(1);
  assign shift_tmp = {maj, shreg};
  assign busy      = (state != ST_IDLE);

  // Next-state and datapath decisions, evaluated only on baud_tick
  always_comb begin
    state_n   = state;
    tick_n    = tick_cnt;
    bit_n     = bit_cnt;
    samp_n    = samp;
    shreg_n   = shreg;
    message_n = message;
    valid_n   = 1'b0;
    fe_n      = 1'b0;
    if (baud_tick) begin
      if (state == ST_START || state == ST_DATA || state == ST_STOP) begin
        tick_n = tick_inc;
        if (tick_cnt == IDX_LO)  samp_n[0] = rx_s;
        if (tick_cnt == IDX_MID) samp_n[1] = rx_s;
      end
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state_n = ST_START;
            tick_n  = TICK_W'(1);
          end
        end
        ST_START: begin
          if (tick_cnt == IDX_HI && maj) begin
            state_n = ST_IDLE;
            tick_n  = '0;
          end else if (tick_cnt == IDX_LAST) begin
            state_n = ST_DATA;
            bit_n   = '0;
          end
        end
        ST_DATA: begin
          if (tick_cnt == IDX_HI) shreg_n = shift_tmp[W:1];
          if (tick_cnt == IDX_LAST) begin
            if (bit_cnt == BIT_LAST) state_n = ST_STOP;
            else                     bit_n   = bit_cnt + BIT_W'(1);
          end
        end
        ST_STOP: begin
          if (tick_cnt == IDX_HI) begin
            tick_n = '0;
            if (maj) begin
              message_n = shreg;
              valid_n   = 1'b1;
              state_n   = ST_IDLE;
            end else begin
              fe_n    = 1'b1;
              state_n = ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          tick_n = '0;
          if (rx_s) state_n = ST_IDLE;
        end
        default: begin
          state_n = ST_IDLE;
          tick_n  = '0;
          bit_n   = '0;
        end
      endcase
    end
  end

  // State, counters, shift register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      samp          <= '0;
      shreg         <= '0;
      message       <= '0;
      valid         <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      state         <= state_n;
      tick_cnt      <= tick_n;
      bit_cnt       <= bit_n;
      samp          <= samp_n;
      shreg         <= shreg_n;
      message       <= message_n;
      valid         <= valid_n;
      framing_error <= fe_n;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed scenarios plus random frames
// checked against a frame-level model (good stop -> byte delivered, bad stop -> error).
module tb_uart_receiver;

  localparam int unsigned W  = 8;
  localparam int unsigned OS = 16;

  logic         clk, rst, baud_tick, rx;
  logic [W-1:0] message;
  logic         valid, framing_error, busy;

  int checks = 0;
  int errors = 0;
  int div    = 1;
  int n_valid = 0, n_fe = 0, n_both = 0;
  logic [W-1:0] msg_q[$];

  uart_receiver #(.UART_BITS_TRANSFERED(W), .OVERSAMPLE(OS)) dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx),
    .message(message), .valid(valid), .framing_error(framing_error), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor sampled away from the active edge
  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      msg_q.push_back(message);
    end
    if (framing_error) n_fe++;
    if (valid && framing_error) n_both++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold rx at lvl for n baud ticks, each tick spanning div clocks
  task automatic hold(input int n, input logic lvl);
    rx = lvl;
    repeat (n) begin
      for (int c = 0; c < div; c++) begin
        baud_tick = (c == div - 1);
        @(posedge clk);
        #1;
      end
    end
    baud_tick = 1'b0;
  endtask

  // One frame: start, data LSB-first (optional one-tick glitch at index 8), stop
  task automatic send(input logic [W-1:0] b, input logic stop_lvl, input int glitch_bit);
    hold(OS, 1'b0);
    for (int i = 0; i < W; i++) begin
      if (i == glitch_bit) begin
        hold(8, b[i]);
        hold(1, ~b[i]);
        hold(OS - 9, b[i]);
      end else begin
        hold(OS, b[i]);
      end
    end
    hold(OS, stop_lvl);
  endtask

  initial begin
    int bv, bf, bq;
    logic [W-1:0] exp_msg, rb, part;
    logic good;
    int gap, exp_v, exp_fe;

    rst = 1'b1; rx = 1'b1; baud_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_message", 32'(message), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_fe", 32'(framing_error), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    hold(4, 1'b1);

    // Clean frame 0xA5
    bv = n_valid; bf = n_fe;
    send(8'hA5, 1'b1, -1);
    hold(4, 1'b1);
    chk("a5_count", 32'(n_valid - bv), 32'd1);
    chk("a5_msg", 32'(message), 32'hA5);
    chk("a5_fe", 32'(n_fe - bf), 32'd0);
    chk("a5_busy", 32'(busy), 32'h0);

    // False start: 4 low ticks then high
    bv = n_valid; bf = n_fe;
    hold(4, 1'b0);
    hold(2, 1'b1);
    chk("fs_busy_mid", 32'(busy), 32'h1);
    hold(OS, 1'b1);
    chk("fs_busy_end", 32'(busy), 32'h0);
    chk("fs_valid", 32'(n_valid - bv), 32'd0);
    chk("fs_fe", 32'(n_fe - bf), 32'd0);
    chk("fs_msg", 32'(message), 32'hA5);

    // Bad stop, long break, then recovery frame
    bv = n_valid; bf = n_fe;
    send(8'h3C, 1'b0, -1);
    hold(40, 1'b0);
    chk("brk_fe", 32'(n_fe - bf), 32'd1);
    chk("brk_busy", 32'(busy), 32'h1);
    chk("brk_msg", 32'(message), 32'hA5);
    chk("brk_valid", 32'(n_valid - bv), 32'd0);
    hold(4, 1'b1);
    chk("brk_exit_busy", 32'(busy), 32'h0);
    send(8'h81, 1'b1, -1);
    hold(4, 1'b1);
    chk("rec_valid", 32'(n_valid - bv), 32'd1);
    chk("rec_msg", 32'(message), 32'h81);
    chk("rec_fe", 32'(n_fe - bf), 32'd1);

    // Back-to-back frames with no idle gap
    bv = n_valid; bq = msg_q.size();
    send(8'h00, 1'b1, -1);
    send(8'hFF, 1'b1, -1);
    hold(4, 1'b1);
    chk("b2b_count", 32'(n_valid - bv), 32'd2);
    chk("b2b_first", 32'(msg_q[bq]), 32'h00);
    chk("b2b_second", 32'(msg_q[bq+1]), 32'hFF);

    // One-tick glitch on data bit 3 rejected by majority
    bv = n_valid;
    send(8'h55, 1'b1, 3);
    hold(4, 1'b1);
    chk("gl_count", 32'(n_valid - bv), 32'd1);
    chk("gl_msg", 32'(message), 32'h55);

    // Reset in the middle of data bit 4
    bv = n_valid; bf = n_fe;
    part = 8'h5A;
    hold(OS, 1'b0);
    for (int i = 0; i < 4; i++) hold(OS, part[i]);
    hold(8, part[4]);
    rst = 1'b1; rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mrst_msg", 32'(message), 32'h0);
    chk("mrst_valid", 32'(valid), 32'h0);
    chk("mrst_fe", 32'(framing_error), 32'h0);
    chk("mrst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    hold(4, 1'b1);
    chk("mrst_nopulse", 32'(n_valid - bv + n_fe - bf), 32'd0);
    send(8'hC3, 1'b1, -1);
    hold(4, 1'b1);
    chk("mrst_count", 32'(n_valid - bv), 32'd1);
    chk("mrst_c3", 32'(message), 32'hC3);

    // Random frames against a frame-level model
    exp_msg = 8'hC3; exp_v = n_valid; exp_fe = n_fe;
    for (int f = 0; f < 20; f++) begin
      div  = int'($urandom_range(1, 3));
      rb   = W'($urandom);
      good = ($urandom_range(0, 4) != 0);
      gap  = good ? int'($urandom_range(0, 4)) : int'($urandom_range(3, 6));
      if (good) begin
        exp_msg = rb;
        exp_v++;
      end else begin
        exp_fe++;
      end
      send(rb, good, -1);
      hold(gap, 1'b1);
      chk("rnd_valid", 32'(n_valid), 32'(exp_v));
      chk("rnd_fe", 32'(n_fe), 32'(exp_fe));
      chk("rnd_msg", 32'(message), 32'(exp_msg));
    end
    hold(4, 1'b1);
    chk("rnd_busy", 32'(busy), 32'h0);
    chk("never_both", 32'(n_both), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter UART_BITS_TRANSFERED, default 8, data bits per frame.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, baud_tick pulses per bit period (even, >=8).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port baud_tick  input  1  one-clk strobe at OVERSAMPLE x bit rate.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port message  output  UART_BITS_TRANSFERED  last correctly framed byte.
REQ-008 SHALL have port valid  output  1  one-clk pulse when message is updated.
REQ-009 SHALL have port framing_error  output  1  one-clk pulse on a bad stop bit.
REQ-010 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer clocked every clk; rx_s is its output; all decisions use rx_s only.
REQ-012 SHALL have states IDLE, START, DATA, STOP, BREAK, and SHALL evaluate state, counters and samples only on clk edges where baud_tick=1.
REQ-013 SHALL define tick index 0 as the baud_tick on which IDLE first sees rx_s=0; the index runs 0..OVERSAMPLE-1 per bit period, then wraps to 0 for the next bit.
REQ-014 SHALL decide each bit by 2-of-3 majority of rx_s sampled at tick indices M-1, M, M+1, where M=OVERSAMPLE/2; decision at index M+1.
REQ-015 IDLE: on baud_tick with rx_s=0, go to START with index 0; otherwise remain.
REQ-016 START: if the majority at index M+1 is 1 (false start), return to IDLE with no output pulse; else go to DATA at the index wrap.
REQ-017 DATA: shift the decided bits into a shift register LSB-first; after bit UART_BITS_TRANSFERED-1 wraps, go to STOP.
REQ-018 STOP: at index M+1, if the majority is 1, load message from the shift register, pulse valid and go to IDLE in that same edge.
REQ-019 STOP: at index M+1, if the majority is 0, leave message unchanged, pulse framing_error and go to BREAK.
REQ-020 BREAK: remain until a baud_tick with rx_s=1, then go to IDLE; a line held low SHALL produce no further pulses.
REQ-021 Latency: valid/framing_error SHALL be registered, asserted the cycle after the deciding baud_tick edge, and deasserted on the next clk.
REQ-022 Because STOP exits at index M+1, a start bit beginning directly after the stop bit SHALL be received (back-to-back frames, no idle gap required).
REQ-023 message SHALL hold its value between valid pulses; valid and framing_error SHALL never assert together.
REQ-024 busy SHALL be combinational from state: high in START, DATA, STOP and BREAK.
REQ-025 Illegal state encodings SHALL return to IDLE on the next baud_tick.
REQ-026 Frame format SHALL be compatible with uart_transmitter at equal OVERSAMPLE: 1 start bit, UART_BITS_TRANSFERED data bits LSB-first, 1 stop bit, no parity.

Reset
REQ-027 While rst=1 at a clk edge: state=IDLE, counters=0, shift register=0, message=0, valid=0, framing_error=0, busy=0, synchronizer flops=1.
REQ-028 rst asserted mid-frame SHALL abandon the frame with no pulse; after rst deasserts, the next full start bit SHALL be received normally.

Verification
REQ-029 Loopback from uart_transmitter, OVERSAMPLE=16, baud_tick every clk, byte 0xA5 -> exactly one valid pulse, message=0xA5, framing_error stays 0, busy low afterward.
REQ-030 rx low for 4 baud_ticks then high -> false start detected at index 9: no pulse, busy back to 0, message unchanged.
REQ-031 Frame 0x3C with stop bit driven 0, line held low 40 ticks, then high, then frame 0x81 -> one framing_error pulse, message stays at its prior value, state stays in BREAK while the line is low, then valid with message=0x81.
REQ-032 Back-to-back frames 0x00 then 0xFF with no idle between stop and start -> two valid pulses, message 0x00 then 0xFF.
REQ-033 Single-baud_tick glitch at index 8 inverting data bit 3 of 0x55 -> majority rejects it, message=0x55.
REQ-034 rst pulsed during data bit 4, then frame 0xC3 -> no pulse from the aborted frame, all outputs 0 after rst, then valid with message=0xC3.
